// File: rtl/sample_path_pkg.sv
// Shared types, constants and helpers for the ADC -> FIR -> DAC sample path.
package sample_path_pkg;

    // Sequencer states for one ADC register read and filter push
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_READ  = 2'd2,
        ST_PUSH  = 2'd3
    } state_e;

    localparam int ADC_CODE_W = 12;    // offset-binary ADC code width
    localparam int ADC_OFFSET = 2048;  // mid-scale code, maps to sample 0
    localparam int SINK_DW    = 13;    // signed filter sink sample width
    localparam int SRC_DW     = 27;    // signed filter source result width

    // Add a small increment to a counter of 'width' bits, clamping at all-ones.
    // Works on a 32-bit container; callers keep the low 'width' bits.
    function automatic logic [31:0] sat_add(input logic [31:0] value,
                                            input logic [1:0]  inc,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, value} + {31'd0, inc};
        max_val = (33'd1 << width) - 33'd1;
        if (sum > max_val) begin
            return max_val[31:0];
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/sample_rate_tick.sv
// Sample-rate divider: one-cycle tick every pDIV enabled cycles.
// The count is frozen while disabled and forced back to 0 by restart, so the
// first tick after a restart lands exactly pDIV cycles later.
module sample_rate_tick #(
    parameter int pDIV = 1000
) (
    input  logic iclk,
    input  logic irst,
    input  logic ienable,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (pDIV > 1) ? $clog2(pDIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(pDIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    // Divider count: cleared by reset/restart, held while disabled
    always_ff @(posedge iclk) begin
        if (irst) begin
            cnt_reg <= '0;
        end else if (restart) begin
            cnt_reg <= '0;
        end else if (ienable) begin
            if (cnt_reg == LAST) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // A restart cycle never ticks, even if the frozen count happens to be LAST
    assign tick = ienable & ~restart & (cnt_reg == LAST);

endmodule

// File: rtl/sample_path_sequencer.sv
// Sequences ADC register reads into the FIR sink and forwards FIR results
// to the DAC FIFO, with overflow / error / sample accounting.
module sample_path_sequencer
    import sample_path_pkg::*;
#(
    parameter int pDAC_DW     = 24,
    parameter int pSAMPLE_DIV = 1000,
    parameter int pRD_LAT     = 2,
    parameter int pCNT_W      = 16
) (
    input  logic                iclk,
    input  logic                irst,
    input  logic                ienable,
    output logic                adc_slave_clk,
    output logic                adc_slave_rn,
    output logic                adc_slave_cs_n,
    output logic                adc_slave_addr,
    output logic                adc_slave_read_n,
    output logic                adc_slave_wr_n,
    input  logic [15:0]         adc_slave_read_data,
    output logic [15:0]         adc_slave_wr_data,
    output logic                filter_rst_n,
    output logic [12:0]         filter_ast_sink_data,
    output logic                filter_ast_sink_valid,
    output logic [1:0]          filter_ast_sink_err,
    input  logic [26:0]         filter_ast_source_data,
    input  logic [1:0]          filter_ast_source_err,
    input  logic                filter_ast_source_valid,
    output logic                dac_rst,
    output logic                dac_write,
    output logic [pDAC_DW-1:0]  dac_write_data,
    input  logic                dac_full,
    output logic                dac_clear,
    output logic [pCNT_W-1:0]   osample_cnt,
    output logic [pCNT_W-1:0]   oovf_cnt,
    output logic [pCNT_W-1:0]   oerr_cnt
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SETUP = ST_SETUP;
    localparam logic [1:0] S_READ  = ST_READ;
    localparam logic [1:0] S_PUSH  = ST_PUSH;

    localparam int RD_W = (pRD_LAT > 1) ? $clog2(pRD_LAT) : 1;
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(pRD_LAT - 1);

    // ---------------------------------------------------------------
    // Enable edge detection and sample tick
    // ---------------------------------------------------------------
    logic ienable_d_reg;
    logic enable_rise;
    logic tick;

    assign enable_rise = ienable & ~ienable_d_reg;

    // Delayed enable for rising-edge detection
    always_ff @(posedge iclk) begin
        if (irst) begin
            ienable_d_reg <= 1'b0;
        end else begin
            ienable_d_reg <= ienable;
        end
    end

    sample_rate_tick #(
        .pDIV(pSAMPLE_DIV)
    ) u_tick (
        .iclk    (iclk),
        .irst    (irst),
        .ienable (ienable),
        .restart (enable_rise),
        .tick    (tick)
    );

    // ---------------------------------------------------------------
    // Read sequencer
    // ---------------------------------------------------------------
    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic [RD_W-1:0] rd_cnt_reg;
    logic            last_read;
    logic            overrun;
    logic [SINK_DW-1:0] sink_next;

    assign last_read = (rd_cnt_reg == RD_LAST);
    // A tick that finds the sequencer busy is lost and reported as an error
    assign overrun   = tick & (state_reg != S_IDLE);
    // Offset-binary code to two's complement around mid-scale
    assign sink_next = {1'b0, adc_slave_read_data[ADC_CODE_W-1:0]} - SINK_DW'(ADC_OFFSET);

    // Next-state decode; a started sequence always runs to completion
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (tick && ienable) state_next = S_SETUP;
            S_SETUP: state_next = S_READ;
            S_READ:  if (last_read) state_next = S_PUSH;
            S_PUSH:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Read-strobe length counter, only runs while in READ
    always_ff @(posedge iclk) begin
        if (irst) begin
            rd_cnt_reg <= '0;
        end else if (state_reg == S_READ && !last_read) begin
            rd_cnt_reg <= rd_cnt_reg + RD_W'(1);
        end else begin
            rd_cnt_reg <= '0;
        end
    end

    logic [SINK_DW-1:0] sink_data_reg;
    logic               sink_valid_reg;

    // Capture on the last READ cycle so the sample is presented during PUSH
    always_ff @(posedge iclk) begin
        if (irst) begin
            sink_data_reg  <= '0;
            sink_valid_reg <= 1'b0;
        end else begin
            sink_valid_reg <= (state_reg == S_READ) && last_read;
            if (state_reg == S_READ && last_read) begin
                sink_data_reg <= sink_next;
            end
        end
    end

    // ---------------------------------------------------------------
    // Filter / FIFO control
    // ---------------------------------------------------------------
    logic filter_rst_n_reg;
    logic dac_clear_reg;

    // Filter held in reset while disabled; FIFO flushed once on enable
    always_ff @(posedge iclk) begin
        if (irst) begin
            filter_rst_n_reg <= 1'b0;
            dac_clear_reg    <= 1'b0;
        end else begin
            filter_rst_n_reg <= ienable;
            dac_clear_reg    <= enable_rise;
        end
    end

    // ---------------------------------------------------------------
    // Output path: filter result -> DAC FIFO
    // ---------------------------------------------------------------
    logic src_accept;
    logic src_err_drop;
    logic src_ovf_drop;
    logic src_write;

    assign src_accept   = filter_ast_source_valid & ienable;
    // Error has priority over FIFO full when both apply
    assign src_err_drop = src_accept & (filter_ast_source_err != 2'b00);
    assign src_ovf_drop = src_accept & ~src_err_drop & dac_full;
    assign src_write    = src_accept & ~src_err_drop & ~dac_full;

    logic               dac_write_reg;
    logic [pDAC_DW-1:0] dac_write_data_reg;

    // Keep the top pDAC_DW bits of the result (sign preserved, LSBs dropped)
    always_ff @(posedge iclk) begin
        if (irst) begin
            dac_write_reg      <= 1'b0;
            dac_write_data_reg <= '0;
        end else begin
            dac_write_reg <= src_write;
            if (src_write) begin
                dac_write_data_reg <= filter_ast_source_data[SRC_DW-1 -: pDAC_DW];
            end
        end
    end

    // ---------------------------------------------------------------
    // Status counters
    // ---------------------------------------------------------------
    logic [pCNT_W-1:0] sample_cnt_reg;
    logic [pCNT_W-1:0] ovf_cnt_reg;
    logic [pCNT_W-1:0] err_cnt_reg;
    logic [1:0]        err_inc;
    logic [1:0]        ovf_inc;
    logic [31:0]       err_sum;
    logic [31:0]       ovf_sum;

    // Overrun and source error in the same cycle both count
    assign err_inc = {1'b0, overrun} + {1'b0, src_err_drop};
    assign ovf_inc = {1'b0, src_ovf_drop};
    assign err_sum = sat_add(32'(err_cnt_reg), err_inc, pCNT_W);
    assign ovf_sum = sat_add(32'(ovf_cnt_reg), ovf_inc, pCNT_W);

    // Sample counter wraps; drop counters saturate
    always_ff @(posedge iclk) begin
        if (irst) begin
            sample_cnt_reg <= '0;
            ovf_cnt_reg    <= '0;
            err_cnt_reg    <= '0;
        end else begin
            if (state_reg == S_PUSH) begin
                sample_cnt_reg <= sample_cnt_reg + pCNT_W'(1);
            end
            ovf_cnt_reg <= ovf_sum[pCNT_W-1:0];
            err_cnt_reg <= err_sum[pCNT_W-1:0];
        end
    end

    // ---------------------------------------------------------------
    // Port assignments
    // ---------------------------------------------------------------
    assign adc_slave_clk     = iclk;
    assign adc_slave_rn      = ~irst;
    assign adc_slave_cs_n    = ~((state_reg == S_SETUP) || (state_reg == S_READ));
    assign adc_slave_addr    = 1'b0;
    assign adc_slave_read_n  = ~(state_reg == S_READ);
    assign adc_slave_wr_n    = 1'b1;
    assign adc_slave_wr_data = 16'd0;

    assign filter_rst_n          = filter_rst_n_reg;
    assign filter_ast_sink_data  = sink_data_reg;
    assign filter_ast_sink_valid = sink_valid_reg;
    assign filter_ast_sink_err   = 2'b00;

    assign dac_rst        = irst;
    assign dac_write      = dac_write_reg;
    assign dac_write_data = dac_write_data_reg;
    assign dac_clear      = dac_clear_reg;

    assign osample_cnt = sample_cnt_reg;
    assign oovf_cnt    = ovf_cnt_reg;
    assign oerr_cnt    = err_cnt_reg;

    // ADC status nibble and truncated result LSBs are intentionally ignored
    logic unused_bits;
    assign unused_bits = ^{adc_slave_read_data[15:12], filter_ast_source_data};

endmodule

// File: tb/tb_sample_path_sequencer.sv
// Directed testbench for sample_path_sequencer.
// Instance a: pSAMPLE_DIV=8, pRD_LAT=2 (normal timing).
// Instance b: pSAMPLE_DIV=4, pRD_LAT=3, pCNT_W=4 (overruns, saturation, wrap).
module tb_sample_path_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- instance a ----------------
    logic        a_irst, a_ienable, a_src_valid, a_full;
    logic [15:0] a_adc_data;
    logic [26:0] a_src_data;
    logic [1:0]  a_src_err;
    logic        a_adc_clk, a_rn, a_cs_n, a_addr, a_read_n, a_wr_n;
    logic [15:0] a_wr_data;
    logic        a_frst_n, a_sink_valid, a_dac_rst, a_dac_write, a_dac_clear;
    logic [12:0] a_sink_data;
    logic [1:0]  a_sink_err;
    logic [23:0] a_dac_data;
    logic [15:0] a_sample_cnt, a_ovf_cnt, a_err_cnt;

    sample_path_sequencer #(
        .pDAC_DW(24), .pSAMPLE_DIV(8), .pRD_LAT(2), .pCNT_W(16)
    ) dut_a (
        .iclk(clk), .irst(a_irst), .ienable(a_ienable),
        .adc_slave_clk(a_adc_clk), .adc_slave_rn(a_rn), .adc_slave_cs_n(a_cs_n),
        .adc_slave_addr(a_addr), .adc_slave_read_n(a_read_n), .adc_slave_wr_n(a_wr_n),
        .adc_slave_read_data(a_adc_data), .adc_slave_wr_data(a_wr_data),
        .filter_rst_n(a_frst_n), .filter_ast_sink_data(a_sink_data),
        .filter_ast_sink_valid(a_sink_valid), .filter_ast_sink_err(a_sink_err),
        .filter_ast_source_data(a_src_data), .filter_ast_source_err(a_src_err),
        .filter_ast_source_valid(a_src_valid),
        .dac_rst(a_dac_rst), .dac_write(a_dac_write), .dac_write_data(a_dac_data),
        .dac_full(a_full), .dac_clear(a_dac_clear),
        .osample_cnt(a_sample_cnt), .oovf_cnt(a_ovf_cnt), .oerr_cnt(a_err_cnt)
    );

    // ---------------- instance b ----------------
    logic        b_irst, b_ienable, b_src_valid, b_full;
    logic [15:0] b_adc_data;
    logic [26:0] b_src_data;
    logic [1:0]  b_src_err;
    logic        b_adc_clk, b_rn, b_cs_n, b_addr, b_read_n, b_wr_n;
    logic [15:0] b_wr_data;
    logic        b_frst_n, b_sink_valid, b_dac_rst, b_dac_write, b_dac_clear;
    logic [12:0] b_sink_data;
    logic [1:0]  b_sink_err;
    logic [23:0] b_dac_data;
    logic [3:0]  b_sample_cnt, b_ovf_cnt, b_err_cnt;

    sample_path_sequencer #(
        .pDAC_DW(24), .pSAMPLE_DIV(4), .pRD_LAT(3), .pCNT_W(4)
    ) dut_b (
        .iclk(clk), .irst(b_irst), .ienable(b_ienable),
        .adc_slave_clk(b_adc_clk), .adc_slave_rn(b_rn), .adc_slave_cs_n(b_cs_n),
        .adc_slave_addr(b_addr), .adc_slave_read_n(b_read_n), .adc_slave_wr_n(b_wr_n),
        .adc_slave_read_data(b_adc_data), .adc_slave_wr_data(b_wr_data),
        .filter_rst_n(b_frst_n), .filter_ast_sink_data(b_sink_data),
        .filter_ast_sink_valid(b_sink_valid), .filter_ast_sink_err(b_sink_err),
        .filter_ast_source_data(b_src_data), .filter_ast_source_err(b_src_err),
        .filter_ast_source_valid(b_src_valid),
        .dac_rst(b_dac_rst), .dac_write(b_dac_write), .dac_write_data(b_dac_data),
        .dac_full(b_full), .dac_clear(b_dac_clear),
        .osample_cnt(b_sample_cnt), .oovf_cnt(b_ovf_cnt), .oerr_cnt(b_err_cnt)
    );

    // Reset values of every output
    task automatic test_reset();
        a_irst = 1'b1; a_ienable = 1'b0; a_src_valid = 1'b0; a_full = 1'b0;
        a_adc_data = 16'h0FFF; a_src_data = '0; a_src_err = 2'b00;
        b_irst = 1'b1; b_ienable = 1'b0; b_src_valid = 1'b0; b_full = 1'b0;
        b_adc_data = 16'h0ABC; b_src_data = '0; b_src_err = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_cs_n, a_read_n} !== 2'b11) begin
            failures++; $display("FAIL reset_cs_read got=%b exp=11", {a_cs_n, a_read_n});
        end
        checks++;
        if ({a_sink_valid, a_dac_write, a_dac_clear} !== 3'b000) begin
            failures++; $display("FAIL reset_strobes got=%b exp=000", {a_sink_valid, a_dac_write, a_dac_clear});
        end
        checks++;
        if ({a_sample_cnt, a_ovf_cnt, a_err_cnt} !== 48'd0) begin
            failures++; $display("FAIL reset_counters got=%h exp=0", {a_sample_cnt, a_ovf_cnt, a_err_cnt});
        end
        checks++;
        if (a_sink_data !== 13'd0 || a_dac_data !== 24'd0) begin
            failures++; $display("FAIL reset_data got=%h/%h exp=0/0", a_sink_data, a_dac_data);
        end
        checks++;
        if ({a_frst_n, a_dac_rst, a_rn} !== 3'b010) begin
            failures++; $display("FAIL reset_rst_lines got=%b exp=010", {a_frst_n, a_dac_rst, a_rn});
        end
        checks++;
        if ({a_wr_n, a_addr, a_wr_data, a_sink_err} !== {1'b1, 1'b0, 16'd0, 2'b00}) begin
            failures++; $display("FAIL reset_constants got=%b/%b/%h/%b exp=1/0/0000/00", a_wr_n, a_addr, a_wr_data, a_sink_err);
        end
        checks++;
        if ({b_cs_n, b_sink_valid, b_err_cnt, b_sample_cnt} !== {1'b1, 1'b0, 4'd0, 4'd0}) begin
            failures++; $display("FAIL reset_b got=%b/%b/%h/%h exp=1/0/0/0", b_cs_n, b_sink_valid, b_err_cnt, b_sample_cnt);
        end
        $display("test_reset done checks=%0d", checks);
        @(negedge clk) a_irst = 1'b0;
        @(negedge clk);
    endtask

    // Enable edge, tick timing, two ADC reads and code conversion
    task automatic test_samples();
        int sv_k [2];
        logic [12:0] sv_d [2];
        int n_sv = 0;
        int rd_low = 0;
        int cs_low = 0;
        int clr_cnt = 0;
        sv_k[0] = 0; sv_k[1] = 0; sv_d[0] = '0; sv_d[1] = '0;
        a_adc_data = 16'h0FFF;
        a_ienable  = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (a_dac_clear !== 1'b1 || a_frst_n !== 1'b1) begin
                    failures++; $display("FAIL enable_edge clear/frst_n got=%b/%b exp=1/1", a_dac_clear, a_frst_n);
                end
            end
            if (a_dac_clear === 1'b1) clr_cnt++;
            if (a_read_n === 1'b0) rd_low++;
            if (a_cs_n === 1'b0) cs_low++;
            if (a_sink_valid === 1'b1) begin
                if (n_sv < 2) begin
                    sv_k[n_sv] = k;
                    sv_d[n_sv] = a_sink_data;
                end
                n_sv++;
                a_adc_data = 16'hA000;
            end
        end
        checks++;
        if (clr_cnt != 1) begin
            failures++; $display("FAIL dac_clear_width got=%0d exp=1", clr_cnt);
        end
        checks++;
        if (n_sv != 2 || sv_k[0] != 12 || sv_k[1] != 20) begin
            failures++; $display("FAIL sink_valid_timing got n=%0d at %0d,%0d exp n=2 at 12,20", n_sv, sv_k[0], sv_k[1]);
        end
        checks++;
        if (sv_d[0] !== 13'h07FF) begin
            failures++; $display("FAIL sink_data_max got=%h exp=07ff", sv_d[0]);
        end
        checks++;
        if (sv_d[1] !== 13'h1800) begin
            failures++; $display("FAIL sink_data_min got=%h exp=1800", sv_d[1]);
        end
        checks++;
        if (rd_low != 4 || cs_low != 6) begin
            failures++; $display("FAIL strobe_lengths got read_n_low=%0d cs_n_low=%0d exp=4/6", rd_low, cs_low);
        end
        checks++;
        if (a_sample_cnt !== 16'd2) begin
            failures++; $display("FAIL osample_cnt got=%0d exp=2", a_sample_cnt);
        end
        $display("test_samples done checks=%0d", checks);
    endtask

    // Truncation of filter results into the DAC FIFO
    task automatic test_dac_write();
        logic [26:0] vin  [4];
        logic [23:0] vexp [4];
        vin[0] = 27'h4000001; vexp[0] = 24'h800000;
        vin[1] = 27'h7FFFFF8; vexp[1] = 24'hFFFFFF;
        vin[2] = 27'h0000007; vexp[2] = 24'h000000;
        vin[3] = 27'h3FFFFFF; vexp[3] = 24'h7FFFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_src_valid = 1'b1; a_src_data = vin[i]; a_full = 1'b0; a_src_err = 2'b00;
            @(negedge clk);
            checks++;
            if (a_dac_write !== 1'b1 || a_dac_data !== vexp[i]) begin
                failures++; $display("FAIL dac_write[%0d] got=%b/%h exp=1/%h", i, a_dac_write, a_dac_data, vexp[i]);
            end
            a_src_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (a_dac_write !== 1'b0) begin
                failures++; $display("FAIL dac_write_idle[%0d] got=%b exp=0", i, a_dac_write);
            end
        end
        $display("test_dac_write done checks=%0d", checks);
    endtask

    // FIFO-full drops and recovery
    task automatic test_overflow();
        int writes = 0;
        @(negedge clk);
        a_src_valid = 1'b1; a_full = 1'b1; a_src_data = 27'h1234567;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_dac_write === 1'b1) writes++;
        end
        a_src_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (writes != 0 || a_ovf_cnt !== 16'd5) begin
            failures++; $display("FAIL overflow_drop got writes=%0d oovf=%0d exp=0/5", writes, a_ovf_cnt);
        end
        a_full = 1'b0; a_src_valid = 1'b1; a_src_data = 27'h0000008;
        @(negedge clk);
        a_src_valid = 1'b0;
        checks++;
        if (a_dac_write !== 1'b1 || a_dac_data !== 24'h000001 || a_ovf_cnt !== 16'd5) begin
            failures++; $display("FAIL overflow_recover got=%b/%h/%0d exp=1/000001/5", a_dac_write, a_dac_data, a_ovf_cnt);
        end
        $display("test_overflow done checks=%0d", checks);
    endtask

    // Source error drops, with priority over FIFO full
    task automatic test_error();
        @(negedge clk);
        a_src_valid = 1'b1; a_src_err = 2'b01; a_full = 1'b0; a_src_data = 27'h4000001;
        @(negedge clk);
        checks++;
        if (a_dac_write !== 1'b0 || a_err_cnt !== 16'd1) begin
            failures++; $display("FAIL source_err got write=%b oerr=%0d exp=0/1", a_dac_write, a_err_cnt);
        end
        a_src_err = 2'b11; a_full = 1'b1;
        @(negedge clk);
        a_src_valid = 1'b0; a_src_err = 2'b00; a_full = 1'b0;
        checks++;
        if (a_err_cnt !== 16'd2 || a_ovf_cnt !== 16'd5 || a_dac_write !== 1'b0) begin
            failures++; $display("FAIL err_priority got oerr=%0d oovf=%0d write=%b exp=2/5/0", a_err_cnt, a_ovf_cnt, a_dac_write);
        end
        $display("test_error done checks=%0d", checks);
    endtask

    // Disabled path: no reads, no writes, filter in reset
    task automatic test_disable();
        int writes = 0;
        int cs_low = 0;
        int svs = 0;
        logic [15:0] snap;
        @(negedge clk);
        a_ienable = 1'b0; a_src_valid = 1'b1; a_src_data = 27'h2AAAAAA;
        repeat (6) begin
            @(negedge clk);
            if (a_dac_write === 1'b1) writes++;
        end
        snap = a_sample_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_dac_write === 1'b1) writes++;
            if (a_cs_n === 1'b0) cs_low++;
            if (a_sink_valid === 1'b1) svs++;
        end
        a_src_valid = 1'b0;
        checks++;
        if (writes != 0 || cs_low != 0 || svs != 0) begin
            failures++; $display("FAIL disabled_activity got writes=%0d cs_low=%0d sink_valid=%0d exp=0/0/0", writes, cs_low, svs);
        end
        checks++;
        if (a_sample_cnt !== snap || a_frst_n !== 1'b0 || a_err_cnt !== 16'd2 || a_ovf_cnt !== 16'd5) begin
            failures++; $display("FAIL disabled_state got samples=%0d frst_n=%b oerr=%0d oovf=%0d exp=%0d/0/2/5", a_sample_cnt, a_frst_n, a_err_cnt, a_ovf_cnt, snap);
        end
        $display("test_disable done checks=%0d", checks);
    endtask

    // Re-enable, then reset in the middle of a READ
    task automatic test_midread_reset();
        int clr_cnt = 0;
        int found = 0;
        int svs = 0;
        int cs_low = 0;
        @(negedge clk);
        a_ienable = 1'b1;
        for (int k = 1; k <= 30 && found == 0; k++) begin
            @(negedge clk);
            if (a_dac_clear === 1'b1) clr_cnt++;
            if (a_read_n === 1'b0) found = k;
        end
        checks++;
        if (clr_cnt != 1 || found != 10) begin
            failures++; $display("FAIL reenable got clear_cycles=%0d first_read=%0d exp=1/10", clr_cnt, found);
        end
        a_irst = 1'b1; a_ienable = 1'b0;
        @(negedge clk);
        checks++;
        if (a_cs_n !== 1'b1 || a_read_n !== 1'b1) begin
            failures++; $display("FAIL midread_abort got cs_n=%b read_n=%b exp=1/1", a_cs_n, a_read_n);
        end
        repeat (2) begin
            @(negedge clk);
            if (a_sink_valid === 1'b1) svs++;
        end
        a_irst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_sink_valid === 1'b1) svs++;
            if (a_cs_n === 1'b0) cs_low++;
        end
        checks++;
        if (svs != 0 || cs_low != 0 || a_sample_cnt !== 16'd0 || a_err_cnt !== 16'd0) begin
            failures++; $display("FAIL midread_after got sink_valid=%0d cs_low=%0d samples=%0d oerr=%0d exp=0/0/0/0", svs, cs_low, a_sample_cnt, a_err_cnt);
        end
        $display("test_midread_reset done checks=%0d", checks);
    endtask

    // Tick overruns, simultaneous errors, saturation and wrap (instance b)
    task automatic test_overrun();
        int svs = 0;
        @(negedge clk) b_irst = 1'b0;
        @(negedge clk) b_ienable = 1'b1;
        for (int k = 1; k <= 141; k++) begin
            @(negedge clk);
            if (b_sink_valid === 1'b1) svs++;
            if (k == 40) begin
                checks++;
                if (b_err_cnt !== 4'd4 || svs != 4 || b_sample_cnt !== 4'd4) begin
                    failures++; $display("FAIL overrun_rate got oerr=%0d sink_valid=%0d samples=%0d exp=4/4/4", b_err_cnt, svs, b_sample_cnt);
                end
                b_src_valid = 1'b1; b_src_err = 2'b01;
            end
            if (k == 41) begin
                checks++;
                if (b_err_cnt !== 4'd6) begin
                    failures++; $display("FAIL overrun_plus_err got oerr=%0d exp=6", b_err_cnt);
                end
                b_src_valid = 1'b0; b_src_err = 2'b00;
            end
        end
        checks++;
        if (b_err_cnt !== 4'hF) begin
            failures++; $display("FAIL err_saturate got=%h exp=f", b_err_cnt);
        end
        checks++;
        if (b_sample_cnt !== 4'd1 || b_ovf_cnt !== 4'd0) begin
            failures++; $display("FAIL sample_wrap got samples=%0d oovf=%0d exp=1/0", b_sample_cnt, b_ovf_cnt);
        end
        $display("test_overrun done checks=%0d", checks);
    endtask

    initial begin
        test_reset();
        test_samples();
        test_dac_write();
        test_overflow();
        test_error();
        test_disable();
        test_midread_reset();
        test_overrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
